// File: rtl/ti_pkg.sv
// Shared types and constants for the task-switch sequencer.
// Holds the FSM state encoding, the task id width and the default timeout.
package ti_pkg;

  localparam int TASK_ID_W              = 1;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STOP    = 3'd1,
    S_SAVE    = 3'd2,
    S_SWAP    = 3'd3,
    S_RESTORE = 3'd4,
    S_RESUME  = 3'd5,
    S_ABORT   = 3'd6
  } state_e;

endpackage

// File: rtl/ti_timeout_cnt.sv
// Quiesce timeout counter: held at zero while clr is high, counts while en is high,
// and flags expire on the last permitted wait cycle.
module ti_timeout_cnt
  import ti_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order in which always blocks evaluate.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // The entry cycle sees cnt == 0, so this fires on the TIMEOUT_CYCLES-th wait cycle.
  assign expire = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ti_switch_ctrl.sv
// Task-switch sequencer: quiesces the wrapper channels, runs save/restore around
// a task_id flip, then releases the channels; aborts if quiescing times out.
module ti_switch_ctrl
  import ti_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 switch_req,
  input  logic [TASK_ID_W-1:0] next_task_id,
  input  logic [NUM_CH-1:0]    ch_mask,
  output logic [NUM_CH-1:0]    stop_req,
  input  logic [NUM_CH-1:0]    stop_ack,
  output logic                 save_start,
  input  logic                 save_done,
  output logic                 restore_start,
  input  logic                 restore_done,
  output logic [TASK_ID_W-1:0] task_id,
  output logic                 busy,
  output logic                 switch_done,
  output logic                 switch_err
);

  state_e                 state, state_d;
  logic [NUM_CH-1:0]      mask_r;
  logic [TASK_ID_W-1:0]   next_r;
  logic                   first_q;
  logic                   expire;
  logic                   all_ack;
  logic                   none_ack;
  logic                   accept;

  ti_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (state != S_STOP),
    .en    (state == S_STOP),
    .expire(expire)
  );

  // Unmasked channels are excluded from both the all-acked and all-released tests.
  assign all_ack  = ((stop_ack & mask_r) == mask_r);
  assign none_ack = ((stop_ack & mask_r) == '0);
  assign accept   = (state == S_IDLE) && switch_req && (next_task_id != task_id);
  assign busy     = (state != S_IDLE);

  // NOTE: every output of this block gets a default before the case statement,
  // so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state;
    stop_req      = '0;
    save_start    = 1'b0;
    restore_start = 1'b0;
    switch_done   = 1'b0;
    switch_err    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_d = (ch_mask == '0) ? S_SAVE : S_STOP;
      end
      S_STOP: begin
        stop_req = mask_r;
        if (all_ack)     state_d = S_SAVE;
        else if (expire) state_d = S_ABORT;
      end
      S_SAVE: begin
        stop_req   = mask_r;
        save_start = first_q;
        if (save_done) state_d = S_SWAP;
      end
      S_SWAP: begin
        stop_req = mask_r;
        state_d  = S_RESTORE;
      end
      S_RESTORE: begin
        stop_req      = mask_r;
        restore_start = first_q;
        if (restore_done) state_d = S_RESUME;
      end
      S_RESUME: begin
        if (none_ack) begin
          switch_done = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_ABORT: begin
        if (none_ack) begin
          switch_err = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      mask_r  <= '0;
      next_r  <= '0;
      task_id <= '0;
      first_q <= 1'b0;
    end else begin
      state   <= state_d;
      first_q <= (state_d != state);
      if (accept) begin
        mask_r <= ch_mask;
        next_r <= next_task_id;
      end
      if (state == S_SWAP) task_id <= next_r;
    end
  end

endmodule

// File: tb/tb_ti_switch_ctrl.sv
// Self-checking bench for ti_switch_ctrl: a phase-level reference model checked
// every cycle, plus directed scenarios with hand-computed cycle expectations.
module tb_ti_switch_ctrl;

  localparam int NUM_CH = 2;
  localparam int TO     = 16;

  localparam int PH_IDLE = 0, PH_STOP = 1, PH_SAVE = 2, PH_SWAP = 3;
  localparam int PH_RESTORE = 4, PH_RESUME = 5, PH_ABORT = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              switch_req;
  logic              next_task_id;
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] stop_req;
  logic [NUM_CH-1:0] stop_ack;
  logic              save_start, save_done;
  logic              restore_start, restore_done;
  logic              task_id, busy, switch_done, switch_err;

  always #5 clk = ~clk;

  ti_switch_ctrl #(.NUM_CH(NUM_CH), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .switch_req   (switch_req),
    .next_task_id (next_task_id),
    .ch_mask      (ch_mask),
    .stop_req     (stop_req),
    .stop_ack     (stop_ack),
    .save_start   (save_start),
    .save_done    (save_done),
    .restore_start(restore_start),
    .restore_done (restore_done),
    .task_id      (task_id),
    .busy         (busy),
    .switch_done  (switch_done),
    .switch_err   (switch_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks which phase of the switch protocol we are in and how
  // long we have been there.
  int              m_phase, m_nxt, m_age;
  logic            m_task, m_next;
  logic [NUM_CH-1:0] m_mask;

  function automatic int step();
    case (m_phase)
      PH_IDLE:    if (switch_req && next_task_id != m_task) return (ch_mask == 0) ? PH_SAVE : PH_STOP;
      PH_STOP: begin
        if ((stop_ack & m_mask) == m_mask) return PH_SAVE;
        if (m_age == TO - 1) return PH_ABORT;
      end
      PH_SAVE:    if (save_done) return PH_SWAP;
      PH_SWAP:    return PH_RESTORE;
      PH_RESTORE: if (restore_done) return PH_RESUME;
      PH_RESUME, PH_ABORT: if ((stop_ack & m_mask) == 0) return PH_IDLE;
      default: ;
    endcase
    return m_phase;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= PH_IDLE;
      m_age   <= 0;
      m_task  <= 1'b0;
      m_next  <= 1'b0;
      m_mask  <= '0;
    end else begin
      m_nxt = step();
      if (m_phase == PH_IDLE && m_nxt != PH_IDLE) begin
        m_mask <= ch_mask;
        m_next <= next_task_id;
      end
      if (m_phase == PH_SWAP) m_task <= m_next;
      m_age   <= (m_nxt == m_phase) ? m_age + 1 : 0;
      m_phase <= m_nxt;
    end
  end

  // Per-cycle compare, 3 time units after the edge; also remembers this cycle's
  // outputs for the wrapper and save-engine responders.
  logic              chk_en = 1'b0;
  logic [NUM_CH-1:0] last_sr = '0;
  logic              last_ss = 1'b0, last_rs = 1'b0;

  always @(posedge clk) begin
    #3;
    last_sr = stop_req;
    last_ss = save_start;
    last_rs = restore_start;
    if (chk_en) begin
      logic in_window;
      in_window = (m_phase >= PH_STOP) && (m_phase <= PH_RESTORE);
      check("cyc_stop_req", stop_req, in_window ? m_mask : '0);
      check("cyc_save_start", save_start, (m_phase == PH_SAVE) && (m_age == 0));
      check("cyc_restore_start", restore_start, (m_phase == PH_RESTORE) && (m_age == 0));
      check("cyc_task_id", task_id, m_task);
      check("cyc_busy", busy, m_phase != PH_IDLE);
      check("cyc_switch_done", switch_done, (m_phase == PH_RESUME) && ((stop_ack & m_mask) == 0));
      check("cyc_switch_err", switch_err, (m_phase == PH_ABORT) && ((stop_ack & m_mask) == 0));
    end
  end

  // Responders: acks follow stop_req one cycle later (minus blocked channels) unless
  // driven manually; done pulses answer start pulses one cycle later.
  logic              auto_ack = 1'b1;
  logic [NUM_CH-1:0] ack_block = '0;
  logic [NUM_CH-1:0] man_ack = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    stop_ack     = auto_ack ? (last_sr & ~ack_block) : man_ack;
    save_done    = last_ss;
    restore_done = last_rs;
    #3;
  endtask

  int sv_cyc, sv_cnt, rs_cyc, rs_cnt, tid_cyc;
  logic [NUM_CH-1:0] sr_log [0:63];
  logic [NUM_CH-1:0] sr_or;

  // Runs one switch from the current cycle (cycle 0) until a done/err pulse,
  // recording the cycle index of each event of interest.
  task automatic run_switch(input int max, output int n);
    logic start_tid;
    start_tid = task_id;
    n = 0; sv_cyc = -1; rs_cyc = -1; tid_cyc = -1; sv_cnt = 0; rs_cnt = 0; sr_or = '0;
    do begin
      tick();
      n++;
      if (n == 1) switch_req = 1'b0;
      if (n < 64) sr_log[n] = stop_req;
      sr_or |= stop_req;
      if (save_start) begin sv_cnt++; if (sv_cyc < 0) sv_cyc = n; end
      if (restore_start) begin rs_cnt++; if (rs_cyc < 0) rs_cyc = n; end
      if (task_id != start_tid && tid_cyc < 0) tid_cyc = n;
    end while (!(switch_done || switch_err) && n < max);
    check("switch_ended", switch_done | switch_err, 1'b1);
  endtask

  task automatic request(input logic nt, input logic [NUM_CH-1:0] m);
    next_task_id = nt;
    ch_mask      = m;
    switch_req   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; switch_req = 1'b0; next_task_id = 1'b0; ch_mask = '0;
    stop_ack = '0; save_done = 1'b0; restore_done = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_stop_req", stop_req, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_task_id", task_id, 1'b0);
    check("rst_pulses", {save_start, restore_start, switch_done, switch_err}, 4'b0);
    rst = 1'b0;
    tick();

    // Basic switch 0 -> 1: STOP c1-c2, SAVE c3-c4, SWAP c5, RESTORE c6-c7,
    // RESUME c8 (acks still high), acks drop at c9 -> switch_done.
    request(1'b1, 2'b11);
    run_switch(40, n);
    check("basic_done_cycle", n, 9);
    check("basic_done_pulse", switch_done, 1'b1);
    check("basic_save_cycle", sv_cyc, 3);
    check("basic_save_count", sv_cnt, 1);
    check("basic_restore_cycle", rs_cyc, 6);
    check("basic_restore_count", rs_cnt, 1);
    check("basic_task_flip_cycle", tid_cyc, 6);
    check("basic_sr_c1", sr_log[1], 2'b11);
    check("basic_sr_c7", sr_log[7], 2'b11);
    check("basic_sr_c8", sr_log[8], 2'b00);
    tick();
    check("basic_idle_busy", busy, 1'b0);
    check("basic_idle_task", task_id, 1'b1);

    // Same-task request is ignored.
    request(1'b1, 2'b11);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("same_busy", busy, 1'b0);
      check("same_pulses", {save_start, switch_done, switch_err, stop_req}, 5'b0);
    end
    switch_req = 1'b0;
    tick();

    // Empty mask 1 -> 0: SAVE at c1, SWAP c3, task visible c4, done c6.
    request(1'b0, 2'b00);
    run_switch(40, n);
    check("mask0_save_cycle", sv_cyc, 1);
    check("mask0_no_stop_req", sr_or, 2'b00);
    check("mask0_task_flip_cycle", tid_cyc, 4);
    check("mask0_done_cycle", n, 6);
    tick();

    // Timeout 0 -> 1 with ch1 never acking: STOP c1..c16, ABORT c17,
    // ch0 ack falls at c18 -> switch_err.
    ack_block = 2'b10;
    request(1'b1, 2'b11);
    run_switch(60, n);
    check("to_err_pulse", switch_err, 1'b1);
    check("to_err_cycle", n, 18);
    check("to_no_save", sv_cnt, 0);
    check("to_sr_last_stop", sr_log[16], 2'b11);
    check("to_sr_abort", sr_log[17], 2'b00);
    check("to_task_kept", task_id, 1'b0);
    ack_block = '0;
    tick();

    // Boundary: ch1 acks on the last STOP cycle (age 15) -> SAVE, not ABORT.
    request(1'b1, 2'b11);
    auto_ack = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      man_ack[0] = (c - 1 >= 1);
      man_ack[1] = (c - 1 >= 15);
      tick();
      if (c == 1) switch_req = 1'b0;
    end
    check("bnd_last_stop_sr", stop_req, 2'b11);
    auto_ack = 1'b1;
    tick();
    check("bnd_save_taken", save_start, 1'b1);
    check("bnd_no_err", switch_err, 1'b0);
    run_switch(40, n);
    check("bnd_done", switch_done, 1'b1);
    check("bnd_task", task_id, 1'b1);
    tick();

    // Staggered acks 1 -> 0: ch0 at STOP age 3, ch1 at age 12 -> SAVE at c14.
    request(1'b0, 2'b11);
    auto_ack = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      man_ack[0] = (c - 1 >= 3);
      man_ack[1] = (c - 1 >= 12);
      tick();
      if (c == 1) switch_req = 1'b0;
      check("stag_no_early_save", save_start, 1'b0);
    end
    auto_ack = 1'b1;
    tick();
    check("stag_save_c14", save_start, 1'b1);
    run_switch(40, n);
    check("stag_done", switch_done, 1'b1);
    check("stag_task", task_id, 1'b0);
    tick();

    // Reset during RESTORE (entered at c6, task already flipped to 1).
    request(1'b1, 2'b11);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) switch_req = 1'b0;
    end while (!restore_start && n < 30);
    check("rr_restore_cycle", n, 6);
    check("rr_task_before", task_id, 1'b1);
    rst = 1'b1;
    tick();
    check("rr_stop_req", stop_req, 2'b00);
    check("rr_task_id", task_id, 1'b0);
    check("rr_busy", busy, 1'b0);
    check("rr_no_pulses", {switch_done, switch_err}, 2'b00);
    rst = 1'b0;
    tick(); tick();

    // Normal switch after the reset.
    request(1'b1, 2'b11);
    run_switch(40, n);
    check("post_done_cycle", n, 9);
    check("post_done", switch_done, 1'b1);
    tick();
    check("post_task", task_id, 1'b1);
    check("post_busy", busy, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
